// File: rtl/mvm_issue_ctrl.sv
// rtl/mvm_issue_ctrl.sv - issue controller for the mat_vec_mult start/done engine
// Optional perf counters (perf_vtx, perf_stall) under MVM_PERF_CNT_EN.
module mvm_issue_ctrl #(
    parameter int GUARD   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic [31:0] in_z,
    output logic        mvm_start,
    output logic [31:0] mvm_v1,
    output logic [31:0] mvm_v2,
    output logic [31:0] mvm_v3,
    input  logic        mvm_done,
    input  logic [31:0] mvm_o1,
    input  logic [31:0] mvm_o2,
    input  logic [31:0] mvm_o3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic [31:0] out_z,
    output logic        busy,
    output logic        err_timeout
`ifdef MVM_PERF_CNT_EN
    ,
    output logic [31:0] perf_vtx,
    output logic [31:0] perf_stall
`endif
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT} state_t;

    state_t          state, state_nx;
    logic            inbuf_full;
    logic [31:0]     inbuf_x, inbuf_y, inbuf_z;
    logic [GW-1:0]   gcnt;
    logic [TW-1:0]   tcnt;
    logic            accept, issue, capture, tmo;

    assign in_ready  = !inbuf_full;
    assign accept    = in_valid && in_ready;
    assign mvm_start = (state == S_ISSUE);
    assign busy      = (state != S_IDLE) || inbuf_full || out_valid;

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        capture  = 1'b0;
        tmo      = 1'b0;
        case (state)
            S_IDLE: begin
                if (inbuf_full && !(out_valid && !out_ready)) begin
                    issue    = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: state_nx = S_GUARD;
            S_GUARD: begin
                if (gcnt == GW'(GUARD - 1)) state_nx = S_WAIT;
            end
            S_WAIT: begin
                // A finished result waits for a free result register rather than overwrite one.
                if (mvm_done) begin
                    if (!out_valid || out_ready) begin
                        capture  = 1'b1;
                        state_nx = S_IDLE;
                    end
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    tmo      = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            inbuf_full  <= 1'b0;
            inbuf_x     <= '0;
            inbuf_y     <= '0;
            inbuf_z     <= '0;
            mvm_v1      <= '0;
            mvm_v2      <= '0;
            mvm_v3      <= '0;
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            out_z       <= '0;
            gcnt        <= '0;
            tcnt        <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nx;

            if (accept) begin
                inbuf_full <= 1'b1;
                inbuf_x    <= in_x;
                inbuf_y    <= in_y;
                inbuf_z    <= in_z;
            end else if (issue) begin
                inbuf_full <= 1'b0;
            end

            if (issue) begin
                mvm_v1 <= inbuf_x;
                mvm_v2 <= inbuf_y;
                mvm_v3 <= inbuf_z;
            end

            if (state == S_ISSUE)      gcnt <= '0;
            else if (state == S_GUARD) gcnt <= gcnt + 1'b1;

            if (state == S_GUARD)                  tcnt <= '0;
            else if (state == S_WAIT && !mvm_done) tcnt <= tcnt + 1'b1;

            if (tmo) err_timeout <= 1'b1;

            if (capture) begin
                out_x     <= mvm_o1;
                out_y     <= mvm_o2;
                out_z     <= mvm_o3;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MVM_PERF_CNT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perf_vtx   <= '0;
            perf_stall <= '0;
        end else begin
            if (capture)                 perf_vtx   <= perf_vtx + 32'd1;
            if (out_valid && !out_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mvm_issue_ctrl.sv
// tb/tb_mvm_issue_ctrl.sv - directed self-checking bench for mvm_issue_ctrl
module tb_mvm_issue_ctrl;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0, in_y = '0, in_z = '0;
    logic        mvm_start;
    logic [31:0] mvm_v1, mvm_v2, mvm_v3;
    logic        mvm_done;
    logic [31:0] mvm_o1, mvm_o2, mvm_o3;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_x, out_y, out_z;
    logic        busy;
    logic        err_timeout;
`ifdef MVM_PERF_CNT_EN
    logic [31:0] perf_vtx, perf_stall;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;

    // engine model: done is an idle level, drops after start, returns after eng_lat cycles
    logic        eng_done;
    logic        glitch = 1'b0;
    int          eng_lat = 25;
    int          eng_cnt;
    logic [31:0] ev1, ev2, ev3;

    assign mvm_done = eng_done | glitch;

    always #5 clock = ~clock;

    mvm_issue_ctrl dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .mvm_start(mvm_start), .mvm_v1(mvm_v1), .mvm_v2(mvm_v2), .mvm_v3(mvm_v3),
        .mvm_done(mvm_done), .mvm_o1(mvm_o1), .mvm_o2(mvm_o2), .mvm_o3(mvm_o3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .busy(busy), .err_timeout(err_timeout)
`ifdef MVM_PERF_CNT_EN
        , .perf_vtx(perf_vtx), .perf_stall(perf_stall)
`endif
    );

    function automatic logic [31:0] f1(input logic [31:0] v); return ~v; endfunction
    function automatic logic [31:0] f2(input logic [31:0] v); return v ^ 32'h0F0F0F0F; endfunction
    function automatic logic [31:0] f3(input logic [31:0] v); return {v[7:0], v[31:8]}; endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            eng_done <= 1'b1;
            eng_cnt  <= 0;
            mvm_o1   <= '0;
            mvm_o2   <= '0;
            mvm_o3   <= '0;
            ev1 <= '0; ev2 <= '0; ev3 <= '0;
        end else if (mvm_start) begin
            eng_done <= 1'b0;
            eng_cnt  <= eng_lat;
            ev1 <= mvm_v1; ev2 <= mvm_v2; ev3 <= mvm_v3;
        end else if (!eng_done && eng_cnt != 0) begin
            if (eng_cnt == 1) begin
                eng_done <= 1'b1;
                mvm_o1   <= f1(ev1);
                mvm_o2   <= f2(ev2);
                mvm_o3   <= f3(ev3);
            end
            eng_cnt <= eng_cnt - 1;
        end
    end

    always @(posedge clock) if (mvm_start) start_cnt <= start_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b0; glitch = 1'b0;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        int n = 0;
        in_valid = 1'b1; in_x = x; in_y = y; in_z = z;
        while (!in_ready && n < 500) begin @(negedge clock); n++; end
        n_cmp++;
        if (n >= 500) begin n_bad++; $display("FAIL send_accept: in_ready stuck 0, required 1"); end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic recv(output logic [31:0] x, output logic [31:0] y, output logic [31:0] z,
                        output bit ok);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 500) begin @(negedge clock); n++; end
        ok = out_valid; x = out_x; y = out_y; z = out_z;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        int n = 0;
        while (!mvm_start && n < 100) begin @(negedge clock); n++; end
        ok = mvm_start;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (in_ready !== 1'b1)    begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (mvm_start !== 1'b0)   begin n_bad++; $display("FAIL reset_start: got %b want 0", mvm_start); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({out_x, mvm_v1} !== 64'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {out_x, mvm_v1}); end
    endtask

    task automatic test_single();
        int s0, n;
        s0 = start_cnt;
        eng_lat = 25;
        send(32'h3F800000, 32'h40000000, 32'h40400000);
        n_cmp++; if (mvm_start !== 1'b0) begin n_bad++; $display("FAIL single_lat_t1: start got %b want 0", mvm_start); end
        @(negedge clock);
        n_cmp++; if (mvm_start !== 1'b1) begin n_bad++; $display("FAIL single_lat_t2: start got %b want 1", mvm_start); end
        n_cmp++; if (busy !== 1'b1)      begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        n = 0;
        while (mvm_done && n < 10) begin @(negedge clock); n++; end
        n = 0;
        while (!mvm_done && n < 100) begin @(negedge clock); n++; end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_pre_capture: out_valid got %b want 0", out_valid); end
        @(negedge clock);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_capture: out_valid got %b want 1", out_valid); end
        n_cmp++;
        if ({out_x, out_y, out_z} !== {32'hC07FFFFF, 32'h4F0F0F0F, 32'h00404000}) begin
            n_bad++; $display("FAIL single_data: got %h %h %h want c07fffff 4f0f0f0f 00404000", out_x, out_y, out_z);
        end
        repeat (5) @(negedge clock);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_hold: out_valid got %b want 1", out_valid); end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: out_valid got %b want 0", out_valid); end
        n_cmp++; if (start_cnt - s0 != 1) begin n_bad++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vx [8];
        logic [31:0] vy [8];
        logic [31:0] vz [8];
        int s0;
        apply_reset();
        s0 = start_cnt;
        eng_lat = 3;
        for (int i = 0; i < 8; i++) begin
            vx[i] = 32'h41000000 + 32'(i * 3);
            vy[i] = 32'hC2800000 ^ 32'(i << 12);
            vz[i] = 32'h12345600 + 32'(i);
        end
        fork
            begin
                for (int i = 0; i < 8; i++) send(vx[i], vy[i], vz[i]);
            end
            begin
                logic [31:0] rx, ry, rz;
                bit ok;
                for (int j = 0; j < 8; j++) begin
                    recv(rx, ry, rz, ok);
                    n_cmp++;
                    if (!ok || {rx, ry, rz} !== {f1(vx[j]), f2(vy[j]), f3(vz[j])}) begin
                        n_bad++;
                        $display("FAIL b2b_data[%0d]: got %h %h %h valid %0d want %h %h %h", j, rx, ry, rz, ok,
                                 f1(vx[j]), f2(vy[j]), f3(vz[j]));
                    end
                end
            end
        join
        n_cmp++; if (start_cnt - s0 != 8) begin n_bad++; $display("FAIL b2b_starts: got %0d want 8", start_cnt - s0); end
`ifdef MVM_PERF_CNT_EN
        n_cmp++; if (perf_vtx !== 32'd8) begin n_bad++; $display("FAIL b2b_perf_vtx: got %0d want 8", perf_vtx); end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] rx, ry, rz;
        bit ok;
        int s0, n;
        s0 = start_cnt;
        eng_lat = 10;
        out_ready = 1'b0;
        send(32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003);
        send(32'h11110004, 32'h22220005, 32'h33330006);
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clock); n++; end
        repeat (20) @(negedge clock);
        n_cmp++; if (start_cnt - s0 != 1) begin n_bad++; $display("FAIL bp_blocked: starts got %0d want 1", start_cnt - s0); end
        n_cmp++; if (in_ready !== 1'b0)   begin n_bad++; $display("FAIL bp_buffered: in_ready got %b want 0", in_ready); end
        n_cmp++; if (out_x !== f1(32'hAAAA0001)) begin n_bad++; $display("FAIL bp_hold_data: got %h want %h", out_x, f1(32'hAAAA0001)); end
        recv(rx, ry, rz, ok);
        n_cmp++;
        if (!ok || {rx, ry, rz} !== {32'h5555FFFE, 32'hB4B40F0D, 32'h03CCCC00}) begin
            n_bad++; $display("FAIL bp_first: got %h %h %h want 5555fffe b4b40f0d 03cccc00", rx, ry, rz);
        end
        recv(rx, ry, rz, ok);
        n_cmp++;
        if (!ok || {rx, ry, rz} !== {32'hEEEEFFFB, 32'h2D2D0F0A, 32'h06333300}) begin
            n_bad++; $display("FAIL bp_second: got %h %h %h want eeeefffb 2d2d0f0a 06333300", rx, ry, rz);
        end
        n_cmp++; if (start_cnt - s0 != 2) begin n_bad++; $display("FAIL bp_starts: got %0d want 2", start_cnt - s0); end
    endtask

    task automatic test_glitch();
        logic [31:0] rx, ry, rz;
        bit ok;
        eng_lat = 25;
        send(32'h01020304, 32'h05060708, 32'h090A0B0C);
        wait_start(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL glitch_start: start got 0 want 1"); end
        glitch = 1'b1;
        repeat (2) @(negedge clock);
        glitch = 1'b0;
        @(negedge clock);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL glitch_ignored: out_valid got %b want 0", out_valid); end
        recv(rx, ry, rz, ok);
        n_cmp++;
        if (!ok || {rx, ry, rz} !== {32'hFEFDFCFB, 32'h0A090807, 32'h0C090A0B}) begin
            n_bad++; $display("FAIL glitch_data: got %h %h %h want fefdfcfb 0a090807 0c090a0b", rx, ry, rz);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        eng_lat = 0;
        send(32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003);
        wait_start(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_start: start got 0 want 1"); end
        n = 0;
        while (!err_timeout && n < 300) begin @(negedge clock); n++; end
        // start cycle + 2 guard cycles + 64 wait cycles
        n_cmp++; if (n != 67) begin n_bad++; $display("FAIL tmo_cycles: got %0d want 67", n); end
        repeat (5) @(negedge clock);
        n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", err_timeout); end
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: busy %b out_valid %b want 0 0", busy, out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rx, ry, rz;
        bit ok;
        eng_lat = 30;
        send(32'h0000FFFF, 32'hFFFF0000, 32'h80000001);
        wait_start(ok);
        repeat (10) @(negedge clock);
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, mvm_start, err_timeout, busy} !== 5'b10000) begin
            n_bad++; $display("FAIL midreset_ctrl: got %b want 10000", {in_ready, out_valid, mvm_start, err_timeout, busy});
        end
        n_cmp++; if ({mvm_v1, out_x} !== 64'd0) begin n_bad++; $display("FAIL midreset_data: got %h want 0", {mvm_v1, out_x}); end
`ifdef MVM_PERF_CNT_EN
        n_cmp++; if (perf_vtx !== 32'd0) begin n_bad++; $display("FAIL midreset_perf: got %0d want 0", perf_vtx); end
`endif
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        eng_lat = 5;
        send(32'h7F7FFFFF, 32'h00800000, 32'hFF800000);
        recv(rx, ry, rz, ok);
        n_cmp++;
        if (!ok || {rx, ry, rz} !== {32'h80800000, 32'h0F8F0F0F, 32'h00FF8000}) begin
            n_bad++; $display("FAIL midreset_next: got %h %h %h want 80800000 0f8f0f0f 00ff8000", rx, ry, rz);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_glitch();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
